// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// Purpose : bundles the command channel, response channel and APB bus of the
//           APB master bridge into one interface.
// Signals :
//   command  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   response : rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   status   : busy
//   APB      : paddr, pwrite, psel, penable, pwdata, prdata, pready
// Modports:
//   master : the bridge's view (drives cmd_ready, rsp_*, busy, APB requests)
//   slave  : the environment's view (command source, response sink, APB slave)
// Handshake: a transfer on a valid/ready channel happens on a rising clk edge
// where valid and ready are both high; a valid source holds its payload
// stable until that edge.
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              busy;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Purpose : turns a valid/ready command into one APB SETUP/ACCESS transfer,
//           waits for pready and returns read data/status on a valid/ready
//           response channel. One transaction outstanding at a time.
// Ports   :
//   clk         in  clock, rising edge
//   rst         in  synchronous active-high reset
//   bus         apb_master_bridge_if.master (command, response, busy, APB)
//   dbg_state_o out FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// Options :
//   APB_TIMEOUT_EN - when defined, an ACCESS phase that sees no pready for
//   TIMEOUT_CYC cycles is abandoned and answered with rsp_err=1. When not
//   defined, ACCESS waits forever and rsp_err is tied to 0.
// All outputs are registered except cmd_ready and busy (state decodes).
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_master_bridge_if.master   bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    // Word-aligned addressing: the low address bits never reach the bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.cmd_addr[1:0];
`ifndef APB_TIMEOUT_EN
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (bus.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Counter holds (ACCESS cycles so far - 1): this is the
                    // TIMEOUT_CYC-th cycle without pready.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign dbg_state_o   = state_q;

endmodule
